// File: rtl/pll_pkg.sv
// Definitions shared between the PLL and its monitor blocks.
package pll_pkg;

  // Phase words are unsigned and wrap modulo 2^PHASE_W.
  localparam int PHASE_W = 8;

  // Lock detector FSM encodings.
  typedef enum logic [1:0] {
    ST_UNLOCKED  = 2'd0,
    ST_ACQUIRING = 2'd1,
    ST_LOCKED    = 2'd2,
    ST_HOLDOVER  = 2'd3
  } lock_state_e;

endpackage

// File: rtl/pll_phase_err.sv
// Wrap-aware phase error magnitude |phase - theta|, range 0..2^(PHASE_W-1).
module pll_phase_err
  import pll_pkg::*;
(
  input  logic [PHASE_W-1:0] phase_i,
  input  logic [PHASE_W-1:0] theta_i,
  output logic [PHASE_W-1:0] err_abs_o
);

  logic [PHASE_W-1:0] diff;
  logic [PHASE_W-1:0] neg;

  // The modulo difference read as two's complement; the most negative value
  // negates to itself, which read unsigned is exactly the half-circle 128.
  always_comb begin
    diff      = phase_i - theta_i;
    neg       = ~diff + {{(PHASE_W-1){1'b0}}, 1'b1};
    err_abs_o = diff[PHASE_W-1] ? neg : diff;
  end

endmodule

// File: rtl/pll_lock_detect.sv
// Hysteretic PLL lock detector: registers the phase error, then runs an
// UNLOCKED/ACQUIRING/LOCKED/HOLDOVER FSM on each valid error sample.
module pll_lock_detect
  import pll_pkg::*;
#(
  parameter int WIN_LOCK   = 8,
  parameter int WIN_UNLOCK = 16,
  parameter int LOCK_CNT   = 64,
  parameter int UNLOCK_CNT = 16,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               clear,
  input  logic [PHASE_W-1:0] phase,
  input  logic [PHASE_W-1:0] theta,
  output logic [PHASE_W-1:0] err_abs,
  output logic [1:0]         state,
  output logic               locked,
  output logic               lock_acq,
  output logic               lock_lost,
  output logic [15:0]        lock_time
);

  localparam logic [PHASE_W-1:0] WIN_LOCK_C   = PHASE_W'(WIN_LOCK);
  localparam logic [PHASE_W-1:0] WIN_UNLOCK_C = PHASE_W'(WIN_UNLOCK);
  localparam logic [CNT_W-1:0]   LOCK_CNT_C   = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0]   UNLOCK_CNT_C = CNT_W'(UNLOCK_CNT);
  localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);

  logic [PHASE_W-1:0] err_c;
  logic [PHASE_W-1:0] err_q;
  logic               s1_vld_q;

  lock_state_e        state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_inc;
  logic [15:0]        lt_q;
  logic               locked_q;
  logic               acq_q;
  logic               lost_q;
  logic               in_lock;
  logic               out_unlock;

  pll_phase_err u_err (
    .phase_i   (phase),
    .theta_i   (theta),
    .err_abs_o (err_c)
  );

  // Stage 1: capture the error on sample strobes; clear discards the sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q    <= '0;
      s1_vld_q <= 1'b0;
    end else if (clear) begin
      err_q    <= '0;
      s1_vld_q <= 1'b0;
    end else if (en) begin
      err_q    <= err_c;
      s1_vld_q <= 1'b1;
    end else begin
      s1_vld_q <= 1'b0;
    end
  end

  // Window decisions on the registered error.
  always_comb begin
    in_lock    = (err_q <= WIN_LOCK_C);
    out_unlock = (err_q > WIN_UNLOCK_C);
    cnt_inc    = cnt_q + CNT_ONE;
  end

  // Stage 2: lock FSM with run counter, acquisition timer and pulse outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_UNLOCKED;
      cnt_q    <= '0;
      lt_q     <= '0;
      locked_q <= 1'b0;
      acq_q    <= 1'b0;
      lost_q   <= 1'b0;
    end else if (clear) begin
      state_q  <= ST_UNLOCKED;
      cnt_q    <= '0;
      lt_q     <= '0;
      locked_q <= 1'b0;
      acq_q    <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      acq_q  <= 1'b0;
      lost_q <= 1'b0;
      if (s1_vld_q) begin
        // Time spent hunting for lock; frozen once locked.
        if ((state_q == ST_UNLOCKED || state_q == ST_ACQUIRING) && lt_q != 16'hFFFF)
          lt_q <= lt_q + 16'd1;
        case (state_q)
          ST_UNLOCKED: begin
            if (in_lock) begin
              state_q <= ST_ACQUIRING;
              cnt_q   <= CNT_ONE;
            end else begin
              cnt_q <= '0;
            end
          end
          ST_ACQUIRING: begin
            if (in_lock) begin
              if (cnt_inc == LOCK_CNT_C) begin
                state_q  <= ST_LOCKED;
                cnt_q    <= '0;
                acq_q    <= 1'b1;
                locked_q <= 1'b1;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              state_q <= ST_UNLOCKED;
              cnt_q   <= '0;
            end
          end
          ST_LOCKED: begin
            if (out_unlock) begin
              state_q <= ST_HOLDOVER;
              cnt_q   <= CNT_ONE;
            end
          end
          ST_HOLDOVER: begin
            if (out_unlock) begin
              if (cnt_inc == UNLOCK_CNT_C) begin
                state_q  <= ST_UNLOCKED;
                cnt_q    <= '0;
                lost_q   <= 1'b1;
                locked_q <= 1'b0;
                lt_q     <= '0;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              state_q <= ST_LOCKED;
              cnt_q   <= '0;
            end
          end
          default: begin
            state_q <= ST_UNLOCKED;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign err_abs   = err_q;
  assign state     = state_q;
  assign locked    = locked_q;
  assign lock_acq  = acq_q;
  assign lock_lost = lost_q;
  assign lock_time = lt_q;

endmodule

// File: tb/tb_pll_lock_detect.sv
// Bench for pll_lock_detect: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a run-length model.
module tb_pll_lock_detect;

  localparam int WL = 8;
  localparam int WU = 16;
  localparam int LC = 64;
  localparam int UC = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        clear = 1'b0;
  logic [7:0]  phase = 8'd0;
  logic [7:0]  theta = 8'd0;
  logic [7:0]  err_abs;
  logic [1:0]  state;
  logic        locked;
  logic        lock_acq;
  logic        lock_lost;
  logic [15:0] lock_time;

  int n_chk = 0;
  int n_fail = 0;

  pll_lock_detect #(
    .WIN_LOCK(WL), .WIN_UNLOCK(WU), .LOCK_CNT(LC), .UNLOCK_CNT(UC), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .clear(clear),
    .phase(phase), .theta(theta),
    .err_abs(err_abs), .state(state), .locked(locked),
    .lock_acq(lock_acq), .lock_lost(lock_lost), .lock_time(lock_time)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Lock status is a boolean; the FSM state is derived from whichever run of
  // consecutive good (while hunting) or bad (while locked) samples is open.
  typedef struct {
    int err;
    bit vld;
    bit lk;
    int good_run;
    int bad_run;
    int lt;
    bit acq;
    bit lost;
  } mdl_t;

  mdl_t m;

  function automatic int mdl_err(int ph, int th);
    int d;
    d = (ph - th + 256) % 256;
    return (d > 128) ? 256 - d : d;
  endfunction

  function automatic mdl_t mdl_zero();
    mdl_t z;
    z.err = 0; z.vld = 0; z.lk = 0; z.good_run = 0; z.bad_run = 0;
    z.lt = 0; z.acq = 0; z.lost = 0;
    return z;
  endfunction

  function automatic mdl_t mdl_step(mdl_t c, bit e, bit cl, int ph, int th);
    mdl_t n;
    n = c;
    n.acq = 0;
    n.lost = 0;
    if (cl) return mdl_zero();
    n.vld = e;
    if (e) n.err = mdl_err(ph, th);
    if (c.vld) begin
      if (!c.lk) begin
        if (n.lt < 65535) n.lt = n.lt + 1;
        n.good_run = (c.err <= WL) ? c.good_run + 1 : 0;
        if (n.good_run == LC) begin
          n.lk = 1; n.acq = 1; n.good_run = 0;
        end
      end else begin
        n.bad_run = (c.err > WU) ? c.bad_run + 1 : 0;
        if (n.bad_run == UC) begin
          n.lk = 0; n.lost = 1; n.bad_run = 0; n.lt = 0;
        end
      end
    end
    return n;
  endfunction

  function automatic int mdl_state(mdl_t c);
    if (!c.lk) return (c.good_run > 0) ? 1 : 0;
    return (c.bad_run > 0) ? 3 : 2;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= mdl_zero();
    else        m <= mdl_step(m, en, clear, int'(phase), int'(theta));
  end

  // Cycle-by-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      chk("m_err_abs",   err_abs,   m.err);
      chk("m_state",     state,     mdl_state(m));
      chk("m_locked",    locked,    m.lk);
      chk("m_lock_acq",  lock_acq,  m.acq);
      chk("m_lock_lost", lock_lost, m.lost);
      chk("m_lock_time", lock_time, m.lt);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_err_abs"},   err_abs,   0);
    chk({tag, "_state"},     state,     0);
    chk({tag, "_locked"},    locked,    0);
    chk({tag, "_lock_acq"},  lock_acq,  0);
    chk({tag, "_lock_lost"}, lock_lost, 0);
    chk({tag, "_lock_time"}, lock_time, 0);
  endtask

  // One valid sample, sometimes followed by an idle gap.
  task automatic sample(input logic [7:0] ph);
    phase = ph;
    en = 1'b1;
    tick();
    if ($urandom_range(0, 3) == 0) begin
      en = 1'b0;
      tick();
    end
  endtask

  initial begin
    int acq_edge;
    int n_acq;
    int seg;
    int mode;
    int e;

    // Reset held with random inputs.
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      phase = 8'($urandom); theta = 8'($urandom);
      en = 1'($urandom); clear = 1'($urandom);
      tick();
    end
    check_zero("rst_hold");
    en = 1'b0; clear = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    check_zero("rst_rel");

    // Acquisition with a constant error of 3.
    theta = 8'd100; phase = 8'd103; en = 1'b1;
    acq_edge = -1; n_acq = 0;
    for (int i = 1; i <= 70; i++) begin
      tick();
      if (lock_acq === 1'b1) begin
        n_acq++;
        if (acq_edge < 0) acq_edge = i;
      end
    end
    chk("acq_edge", acq_edge, 65);
    chk("acq_pulses", n_acq, 1);
    chk("acq_locked", locked, 1);
    chk("acq_lock_time", lock_time, 64);

    // Wrap-aware error extremes.
    theta = 8'd250; phase = 8'd4; tick();
    chk("wrap_err10", err_abs, 10);
    theta = 8'd0; phase = 8'd128; tick();
    chk("wrap_err128", err_abs, 128);
    theta = 8'd77; phase = 8'd77; tick();
    chk("wrap_err0", err_abs, 0);
    tick();
    chk("wrap_state", state, 2);

    // Hysteresis: 15 bad samples then a tolerable one keeps lock.
    theta = 8'd0; phase = 8'd20;
    repeat (15) tick();
    phase = 8'd12; tick(); tick();
    chk("hyst15_state", state, 2);
    chk("hyst15_locked", locked, 1);
    repeat (10) tick();
    chk("hyst12_state", state, 2);
    phase = 8'd20;
    repeat (16) tick();
    en = 1'b0; tick();
    chk("hyst16_lost", lock_lost, 1);
    chk("hyst16_locked", locked, 0);
    chk("hyst16_time", lock_time, 0);
    chk("hyst16_state", state, 0);

    // Acquisition broken by a single err 9 sample, with idle gaps.
    theta = 8'd50;
    repeat (30) sample(8'd53);
    sample(8'd59);
    en = 1'b0; tick();
    chk("brk_state", state, 0);
    repeat (64) sample(8'd53);
    en = 1'b0; tick();
    chk("brk_locked", locked, 1);
    chk("brk_time", lock_time, 95);

    // Asynchronous reset in the middle of HOLDOVER.
    phase = 8'd73; en = 1'b1;
    repeat (5) tick();
    en = 1'b0; tick();
    chk("ho_state", state, 3);
    reset = 1'b0;
    #1;
    check_zero("ho_rst");
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();
    check_zero("ho_rel");

    // Clear with a simultaneous in-window sample while locked.
    phase = 8'd50; en = 1'b1;
    repeat (66) tick();
    chk("clr_pre_locked", locked, 1);
    clear = 1'b1; tick();
    clear = 1'b0; en = 1'b0;
    check_zero("clr");
    tick();
    chk("clr_disc_state", state, 0);
    chk("clr_disc_time", lock_time, 0);

    // Randomized traffic in segments of similar error magnitude.
    for (int s = 0; s < 30; s++) begin
      seg = $urandom_range(20, 150);
      mode = $urandom_range(0, 3);
      for (int c = 0; c < seg; c++) begin
        case (mode)
          0:       e = $urandom_range(0, 8);
          1:       e = $urandom_range(9, 16);
          2:       e = $urandom_range(17, 128);
          default: e = $urandom_range(0, 128);
        endcase
        theta = 8'($urandom);
        phase = ($urandom_range(0, 1) == 1) ? 8'(int'(theta) + e) : 8'(int'(theta) - e);
        en    = ($urandom_range(0, 9) != 0);
        clear = ($urandom_range(0, 399) == 0);
        tick();
      end
    end
    en = 1'b0; clear = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
